// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_pkg
//  Description : Shared definitions for the microwave controller and display
//                path: 7-segment glyph constants, the binary-to-BCD converter
//                state type, and small combinational helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package microwave_pkg;

    // Number of binary input bits converted by the BCD converter.
    localparam int c_BIN_BITS = 7;

    // 7-segment glyphs, bit0 = a .. bit6 = g, active-high.
    localparam logic [6:0] c_SEG_BLANK = 7'h00;
    localparam logic [6:0] c_SEG_0     = 7'h3F;
    localparam logic [6:0] c_SEG_1     = 7'h06;
    localparam logic [6:0] c_SEG_2     = 7'h5B;
    localparam logic [6:0] c_SEG_3     = 7'h4F;
    localparam logic [6:0] c_SEG_4     = 7'h66;
    localparam logic [6:0] c_SEG_5     = 7'h6D;
    localparam logic [6:0] c_SEG_6     = 7'h7D;
    localparam logic [6:0] c_SEG_7     = 7'h07;
    localparam logic [6:0] c_SEG_8     = 7'h7F;
    localparam logic [6:0] c_SEG_9     = 7'h6F;

    // Converter sequencing: sample, shift 7 times, publish result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Glyph for one BCD digit; non-decimal codes render blank.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = c_SEG_BLANK;
        case (digit)
            4'd0: seg = c_SEG_0;
            4'd1: seg = c_SEG_1;
            4'd2: seg = c_SEG_2;
            4'd3: seg = c_SEG_3;
            4'd4: seg = c_SEG_4;
            4'd5: seg = c_SEG_5;
            4'd6: seg = c_SEG_6;
            4'd7: seg = c_SEG_7;
            4'd8: seg = c_SEG_8;
            4'd9: seg = c_SEG_9;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 so that the
    // following left shift carries correctly into the next decade.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-add-3 binary to BCD converter for 0..127.
//                Runs continuously: IDLE samples bin, SHIFT performs seven
//                adjust+shift iterations, DONE publishes the result and
//                raises done for one cycle on the following cycle.
//  Ports       : clk, reset (async, active-high)
//                bin[6:0]                 - binary value to convert
//                hundreds/tens/units[3:0] - last completed result
//                done                     - one-cycle pulse when result updates
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import microwave_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       done
);

    localparam logic [2:0] c_LAST_ITER = 3'(c_BIN_BITS - 1);

    conv_state_t r_state;
    conv_state_t w_state_next;

    logic [6:0]  r_bin;    // binary bits still to be shifted in, MSB first
    logic [11:0] r_bcd;    // accumulating BCD digits {hundreds, tens, units}
    logic [2:0]  r_iter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = SHIFT;
            SHIFT:   if (r_iter == c_LAST_ITER) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_iter   <= '0;
            hundreds <= '0;
            tens     <= '0;
            units    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Input is captured once here; later changes wait for
                    // the next pass.
                    r_bin  <= bin;
                    r_bcd  <= '0;
                    r_iter <= '0;
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {bcd_adjust(r_bcd), r_bin} << 1;
                    r_iter         <= r_iter + 3'd1;
                end
                DONE: begin
                    hundreds <= r_bcd[11:8];
                    tens     <= r_bcd[7:4];
                    units    <= r_bcd[3:0];
                    done     <= 1'b1;
                end
                default: begin
                    r_iter <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner
//  Description : Time-multiplexed driver for a 7-digit, 7-segment display:
//                four letter digits followed by hundreds/tens/units of the
//                remaining time, with per-slot dead time, leading-zero
//                blanking and frame-coherent content latching.
//  Ports       : clk, reset (async, active-high)
//                state_display1..4[6:0] - letter glyphs (bit0=a .. bit6=g)
//                time_display[6:0]      - remaining time, binary 0..127
//                seg[6:0]               - shared segment bus, active-high
//                digit_sel[6:0]         - one-hot digit enable, active-high
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
    import microwave_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] state_display1,
    input  logic [6:0] state_display2,
    input  logic [6:0] state_display3,
    input  logic [6:0] state_display4,
    input  logic [6:0] time_display,
    output logic [6:0] seg,
    output logic [6:0] digit_sel
);

    localparam logic [15:0] c_SLOT_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] c_BLANK      = 16'(BLANK_CYCLES);
    localparam logic [2:0]  c_DIG_HUND   = 3'd4;
    localparam logic [2:0]  c_DIG_TENS   = 3'd5;
    localparam logic [2:0]  c_DIG_UNITS  = 3'd6;
    localparam logic [2:0]  c_DIGIT_LAST = 3'd6;

    logic [15:0]     r_slot;
    logic [2:0]      r_digit;
    logic            w_slot_wrap;
    logic            w_frame_wrap;

    logic [3:0]      w_conv_h;
    logic [3:0]      w_conv_t;
    logic [3:0]      w_conv_u;
    logic            w_conv_done;

    logic [3:0]      r_shadow_h;
    logic [3:0]      r_shadow_t;
    logic [3:0]      r_shadow_u;

    logic [3:0][6:0] r_disp_let;
    logic [3:0]      r_disp_h;
    logic [3:0]      r_disp_t;
    logic [3:0]      r_disp_u;

    logic [6:0]      w_seg;
    logic [6:0]      w_sel;
    logic [6:0]      r_seg;
    logic [6:0]      r_sel;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .bin      (time_display),
        .hundreds (w_conv_h),
        .tens     (w_conv_t),
        .units    (w_conv_u),
        .done     (w_conv_done)
    );

    assign w_slot_wrap  = (r_slot == c_SLOT_LAST);
    assign w_frame_wrap = w_slot_wrap && (r_digit == c_DIGIT_LAST);

    // Slot timer and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot  <= '0;
            r_digit <= '0;
        end else if (w_slot_wrap) begin
            r_slot  <= '0;
            r_digit <= (r_digit == c_DIGIT_LAST) ? 3'd0 : r_digit + 3'd1;
        end else begin
            r_slot <= r_slot + 16'd1;
        end
    end

    // Shadow holds the latest finished conversion until the next frame edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow_h <= '0;
            r_shadow_t <= '0;
            r_shadow_u <= '0;
        end else if (w_conv_done) begin
            r_shadow_h <= w_conv_h;
            r_shadow_t <= w_conv_t;
            r_shadow_u <= w_conv_u;
        end
    end

    // Content only changes at the 6->0 wrap so a frame never mixes old/new.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_let <= '0;
            r_disp_h   <= '0;
            r_disp_t   <= '0;
            r_disp_u   <= '0;
        end else if (w_frame_wrap) begin
            r_disp_let <= {state_display4, state_display3,
                           state_display2, state_display1};
            r_disp_h   <= r_shadow_h;
            r_disp_t   <= r_shadow_t;
            r_disp_u   <= r_shadow_u;
        end
    end

    always_comb begin
        w_seg = c_SEG_BLANK;
        w_sel = 7'b1 << r_digit;
        case (r_digit)
            3'd0, 3'd1, 3'd2, 3'd3: w_seg = r_disp_let[r_digit[1:0]];
            c_DIG_HUND:  w_seg = (r_disp_h == 4'd0) ? c_SEG_BLANK
                                                    : seg7_encode(r_disp_h);
            c_DIG_TENS:  w_seg = (r_disp_h == 4'd0 && r_disp_t == 4'd0)
                                 ? c_SEG_BLANK : seg7_encode(r_disp_t);
            c_DIG_UNITS: w_seg = seg7_encode(r_disp_u);
            default:     w_seg = c_SEG_BLANK;
        endcase
    end

    // Output register: one cycle behind the slot/index it reflects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= '0;
            r_sel <= '0;
        end else if (r_slot < c_BLANK) begin
            r_seg <= '0;
            r_sel <= '0;
        end else begin
            r_seg <= w_seg;
            r_sel <= w_sel;
        end
    end

    assign seg       = r_seg;
    assign digit_sel = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scanner
//  Description : Self-checking bench for display_scanner with a cycle-level
//                reference model derived from edge counts since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_display_scanner;

    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int DIGITS   = 7;
    localparam int FRAME    = SCAN_DIV * DIGITS;
    localparam int SETTLE   = 22;  // edges after a time change before shadow is trusted

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] sd1 = '0, sd2 = '0, sd3 = '0, sd4 = '0;
    logic [6:0] time_display = '0;
    logic [6:0] seg;
    logic [6:0] digit_sel;

    always #5 clk = ~clk;

    display_scanner #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .state_display1 (sd1),
        .state_display2 (sd2),
        .state_display3 (sd3),
        .state_display4 (sd4),
        .time_display   (time_display),
        .seg            (seg),
        .digit_sel      (digit_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // ---------------- reference model ----------------
    int unsigned m_edges;
    logic [6:0]  m_let [4];
    int          m_h, m_t, m_u;
    bit          m_bcd_ok;
    int unsigned m_chg;
    logic [6:0]  m_last_time;
    logic [6:0]  exp_seg, exp_sel;
    bit          exp_seg_known;
    bit          m_live = 1'b0;
    int          m_slot, m_digit;

    always @(posedge clk) begin
        if (reset) begin
            m_edges = 0;
            for (int i = 0; i < 4; i++) m_let[i] = '0;
            m_h = 0; m_t = 0; m_u = 0;
            m_bcd_ok = 1'b1;
            m_chg = 0;
            m_last_time = time_display;
            exp_seg = '0; exp_sel = '0; exp_seg_known = 1'b1;
            m_live = 1'b0;
        end else begin
            m_slot  = m_edges % SCAN_DIV;
            m_digit = (m_edges / SCAN_DIV) % DIGITS;
            exp_seg_known = 1'b1;
            exp_seg = '0;
            exp_sel = '0;
            if (m_slot >= BLANK) begin
                exp_sel = 7'(1 << m_digit);
                if (m_digit < 4)        exp_seg = m_let[m_digit];
                else if (!m_bcd_ok)     exp_seg_known = 1'b0;
                else if (m_digit == 4)  exp_seg = (m_h == 0) ? 7'h00 : seg_tab[m_h];
                else if (m_digit == 5)  exp_seg = (m_h == 0 && m_t == 0) ? 7'h00 : seg_tab[m_t];
                else                    exp_seg = seg_tab[m_u];
            end
            if (time_display != m_last_time) begin
                m_last_time = time_display;
                m_chg = m_edges;
            end
            m_edges++;
            if (m_edges % FRAME == 0) begin
                m_let[0] = sd1; m_let[1] = sd2; m_let[2] = sd3; m_let[3] = sd4;
                m_h = time_display / 100;
                m_t = (time_display / 10) % 10;
                m_u = time_display % 10;
                m_bcd_ok = (m_edges - m_chg) >= SETTLE;
            end
            m_live = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_live && !reset) begin
            chk("digit_sel", 32'(digit_sel), 32'(exp_sel));
            if (exp_seg_known) chk($sformatf("seg_d%0d", m_digit), 32'(seg), 32'(exp_seg));
        end
    end

    // ---------------- stimulus ----------------
    bit found;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sel(input logic [6:0] val, input string tag);
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (digit_sel == val) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        tick(3);
        chk("por_seg", 32'(seg), 32'h0);
        chk("por_sel", 32'(digit_sel), 32'h0);
        reset = 1'b0;

        // Scan timing plus 3-digit value and leading-zero blanking.
        time_display = 7'd127; tick(3 * FRAME);
        time_display = 7'd5;   tick(3 * FRAME);
        time_display = 7'd40;  tick(3 * FRAME);

        // Frame coherence: change letter 2 while digit 3 is lit.
        sd2 = 7'h38; tick(2 * FRAME);
        wait_sel(7'b0001000, "wait_digit3");
        sd2 = 7'h3F;
        wait_sel(7'b0000010, "wait_digit1");
        chk("coherent_d1", 32'(seg), 32'h3F);
        tick(FRAME);

        // Reset in the middle of a conversion.
        time_display = 7'd99; tick(2 * FRAME);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (u_dut.u_bin2bcd.r_state == microwave_pkg::SHIFT && digit_sel != 7'd0) found = 1'b1;
        end
        chk("wait_shift", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_sel", 32'(digit_sel), 32'h0);
        chk("rst_slot", 32'(u_dut.r_slot), 32'h0);
        chk("rst_digit", 32'(u_dut.r_digit), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(3 * FRAME);

        // Converter sweep.
        for (int v = 0; v < 128; v++) begin
            time_display = 7'(v);
            tick(20);
            chk("bcd_h", 32'(u_dut.u_bin2bcd.hundreds), 32'(v / 100));
            chk("bcd_t", 32'(u_dut.u_bin2bcd.tens), 32'((v / 10) % 10));
            chk("bcd_u", 32'(u_dut.u_bin2bcd.units), 32'(v % 10));
        end

        // Randomized letters and time values with mid-frame letter changes.
        for (int r = 0; r < 12; r++) begin
            int hold, k;
            sd1 = 7'($urandom); sd2 = 7'($urandom);
            sd3 = 7'($urandom); sd4 = 7'($urandom);
            time_display = 7'($urandom_range(0, 127));
            hold = $urandom_range(2 * FRAME, 3 * FRAME);
            k = $urandom_range(1, FRAME);
            tick(k);
            case ($urandom_range(0, 3))
                0: sd1 = 7'($urandom);
                1: sd2 = 7'($urandom);
                2: sd3 = 7'($urandom);
                default: sd4 = 7'($urandom);
            endcase
            tick(hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
